// File: rtl/menu_pkg.sv
// menu_pkg: shared FSM state type, RGB444 colors and pixel latency for the menu screen
package menu_pkg;
  typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM, DONE} menu_state_t;
  localparam logic [11:0] MENU_BLACK        = 12'h000;
  localparam logic [11:0] MENU_BOX_COLOR    = 12'h444;
  localparam logic [11:0] MENU_HILITE_COLOR = 12'hFF0;
  localparam int          MENU_PIX_LAT      = 2;
endpackage

// File: rtl/menu_screen_button_event.sv
// button_event: rising-edge event for one debounced button; MENU_AUTOREPEAT_EN adds hold-to-repeat steps
module button_event
`ifdef MENU_AUTOREPEAT_EN
  #(parameter int REPEAT_CYCLES = 2_000_000)
`endif
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
`ifdef MENU_AUTOREPEAT_EN
  input  logic hold_en_in,
`endif
  output logic event_out
);
  logic prev;
  // Button history, updated every cycle regardless of menu state
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) prev <= 1'b0;
    else prev <= btn_in;
`ifdef MENU_AUTOREPEAT_EN
  localparam int CW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic hold;
  assign hold = hold_en_in & btn_in & prev;
  // Hold counter: wraps on each repeat step, clears as soon as the hold is broken
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) cnt <= '0;
    else cnt <= (hold && cnt != LAST) ? cnt + 1'b1 : '0;
  assign event_out = (btn_in & ~prev) | (hold & (cnt == LAST));
`else
  assign event_out = btn_in & ~prev;
`endif
endmodule

// File: rtl/menu_screen.sv
// menu_screen: N-option box menu over the camera feed with wrap-around highlight and confirm pulse; MENU_AUTOREPEAT_EN enables hold-to-repeat
module menu_screen
  import menu_pkg::*;
#(
  parameter int          NUM_OPTIONS   = 5,
  parameter int          SEL_W         = $clog2(NUM_OPTIONS),
  parameter int          DEFAULT_SEL   = 0,
  parameter int          BOX_X0        = 64,
  parameter int          BOX_Y0        = 600,
  parameter int          BOX_W         = 160,
  parameter int          BOX_H         = 96,
  parameter int          BOX_GAP       = 32,
  parameter logic [11:0] BOX_COLOR     = MENU_BOX_COLOR,
  parameter logic [11:0] HILITE_COLOR  = MENU_HILITE_COLOR,
  parameter int          REPEAT_CYCLES = 2_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             active_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic [3:0]       cam_img,
  input  logic             left_in,
  input  logic             right_in,
  input  logic             middle_in,
  output logic [11:0]      pixel_out,
  output logic [SEL_W-1:0] select_out,
  output logic             done_out
);
  if (NUM_OPTIONS < 2 || NUM_OPTIONS > 8 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("menu_screen: NUM_OPTIONS must be 2..8 and REPEAT_CYCLES >= 1");
  end

  menu_state_t state;
  logic browse, l_ev, r_ev, m_ev;
  logic [SEL_W-1:0] sel_inc, sel_dec;
  assign browse = state == BROWSE;

  button_event
`ifdef MENU_AUTOREPEAT_EN
    #(.REPEAT_CYCLES(REPEAT_CYCLES))
`endif
    u_left (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (left_in),
`ifdef MENU_AUTOREPEAT_EN
    .hold_en_in(browse & ~right_in),
`endif
    .event_out (l_ev)
  );

  button_event
`ifdef MENU_AUTOREPEAT_EN
    #(.REPEAT_CYCLES(REPEAT_CYCLES))
`endif
    u_right (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (right_in),
`ifdef MENU_AUTOREPEAT_EN
    .hold_en_in(browse & ~left_in),
`endif
    .event_out (r_ev)
  );

  button_event
`ifdef MENU_AUTOREPEAT_EN
    #(.REPEAT_CYCLES(REPEAT_CYCLES))
`endif
    u_middle (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (middle_in),
`ifdef MENU_AUTOREPEAT_EN
    .hold_en_in(1'b0),
`endif
    .event_out (m_ev)
  );

  // Wrap-around neighbours of the current selection
  always_comb begin
    sel_inc = select_out == SEL_W'(NUM_OPTIONS - 1) ? '0 : select_out + 1'b1;
    sel_dec = select_out == '0 ? SEL_W'(NUM_OPTIONS - 1) : select_out - 1'b1;
  end

  // Menu FSM: browse with left/right, middle confirms with a one-cycle done pulse
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state      <= IDLE;
      select_out <= '0;
      done_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: if (active_in) begin
          state      <= BROWSE;
          select_out <= SEL_W'(DEFAULT_SEL);
        end
        BROWSE: if (!active_in) state <= IDLE;
          else if (m_ev) begin
            state    <= CONFIRM;
            done_out <= 1'b1;
          end
          else if (l_ev && !r_ev) select_out <= sel_dec;
          else if (r_ev && !l_ev) select_out <= sel_inc;
        CONFIRM: state <= DONE;
        default: if (!active_in) state <= IDLE;
      endcase
    end

  logic [31:0] hx, vy;
  logic y_hit;
  logic [NUM_OPTIONS-1:0] in_box, in_box_q;
  logic [3:0] cam_q;
  logic [SEL_W-1:0] sel_q;
  logic draw_q;
  assign hx    = 32'(hcount_in);
  assign vy    = 32'(vcount_in);
  assign y_hit = vy >= 32'(BOX_Y0) && vy < 32'(BOX_Y0 + BOX_H);

  for (genvar k = 0; k < NUM_OPTIONS; k++) begin : g_box
    localparam logic [31:0] X0 = 32'(BOX_X0 + k * (BOX_W + BOX_GAP));
    assign in_box[k] = y_hit && hx >= X0 && hx < X0 + 32'(BOX_W);
  end

  // Stage 1: box hits, camera pixel, selection and draw flag
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      in_box_q <= '0;
      cam_q    <= '0;
      sel_q    <= '0;
      draw_q   <= 1'b0;
    end else begin
      in_box_q <= in_box;
      cam_q    <= cam_img;
      sel_q    <= select_out;
      draw_q   <= state != IDLE;
    end

  // Stage 2: colour select between highlight, plain box and grayscale camera
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) pixel_out <= MENU_BLACK;
    else pixel_out <= !draw_q ? MENU_BLACK :
                      |in_box_q ? (in_box_q[sel_q] ? HILITE_COLOR : BOX_COLOR) :
                      {cam_q, cam_q, cam_q};
endmodule

// File: tb/tb_menu_screen.sv
// tb_menu_screen: scoreboard bench for menu_screen against a behavioural menu model
module tb_menu_screen;
  localparam int N   = 5;
  localparam int DEF = 0;
  localparam int X0  = 64;
  localparam int Y0  = 600;
  localparam int W   = 160;
  localparam int H   = 96;
  localparam int G   = 32;
  localparam int RC  = 4;
`ifdef MENU_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic active = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [3:0]  cam = '0;
  logic [11:0] pixel;
  logic [2:0]  sel;
  logic        done;

  menu_screen #(.NUM_OPTIONS(N), .REPEAT_CYCLES(RC)) dut (
    .clk_in(clk), .rst_in(rst), .active_in(active), .hcount_in(hcount), .vcount_in(vcount),
    .cam_img(cam), .left_in(left), .right_in(right), .middle_in(middle),
    .pixel_out(pixel), .select_out(sel), .done_out(done)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int s; int d;} ctrl_e;
  typedef struct {int due; int v;} pix_e;
  ctrl_e ctrl_q[$];
  pix_e  pix_q[$];
  int tests = 0, fails = 0, cyc = 0;

  // model: menu mode (0 off, 1 choosing, 2 just confirmed, 3 frozen), chosen box, last buttons, hold runs
  int ms = 0, msel = 0, lrun = 0, rrun = 0;
  bit pl = 0, pr = 0, pm = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_pix(input bit draw, input int s, input int x, input int y, input int c);
    int dx, k;
    if (!draw) return 0;
    if (y >= Y0 && y < Y0 + H && x >= X0) begin
      dx = x - X0;
      k  = dx / (W + G);
      if (k < N && dx % (W + G) < W) return k == s ? 'hFF0 : 'h444;
    end
    return c * 'h111;
  endfunction

  task automatic step(input bit a, input bit l, input bit r, input bit m, input int x, input int y, input int c);
    bit le, re, me;
    @(negedge clk);
    active = a; left = l; right = r; middle = m;
    hcount = 11'(x); vcount = 10'(y); cam = 4'(c);
    pix_q.push_back('{cyc + 2, exp_pix(ms != 0, msel, x % 2048, y % 1024, c % 16)});
    lrun = (ms == 1 && l && !r && pl) ? lrun + 1 : 0;
    rrun = (ms == 1 && r && !l && pr) ? rrun + 1 : 0;
    le = (l && !pl) || (AR && lrun > 0 && lrun % RC == 0);
    re = (r && !pr) || (AR && rrun > 0 && rrun % RC == 0);
    me = m && !pm;
    pl = l; pr = r; pm = m;
    if (ms == 0) begin
      if (a) begin ms = 1; msel = DEF; end
    end else if (ms == 1) begin
      if (!a) ms = 0;
      else if (me) ms = 2;
      else if (le && !re) msel = (msel + N - 1) % N;
      else if (re && !le) msel = (msel + 1) % N;
    end else if (ms == 2) ms = 3;
    else if (!a) ms = 0;
    ctrl_q.push_back('{cyc + 1, msel, ms == 2 ? 1 : 0});
  endtask

  task automatic idle_step(input bit a);
    step(a, 0, 0, 0, 0, 0, 7);
  endtask

  task automatic press(input bit l, input bit r, input bit m);
    step(1, l, r, m, 0, 0, 7);
    idle_step(1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    active = 0; left = 0; right = 0; middle = 0;
    rst = 1'b1;
    #1;
    chk("rst_select", int'(sel), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pixel", int'(pixel), 0);
    ctrl_q.delete();
    pix_q.delete();
    ms = 0; msel = 0; lrun = 0; rrun = 0; pl = 0; pr = 0; pm = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: after each edge, compare DUT outputs to whatever the scoreboard says is due
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cyc++;
      while (ctrl_q.size() > 0 && ctrl_q[0].due < cyc) begin
        chk("ctrl_missed", ctrl_q[0].due, cyc);
        void'(ctrl_q.pop_front());
      end
      if (ctrl_q.size() > 0 && ctrl_q[0].due == cyc) begin
        chk("select", int'(sel), ctrl_q[0].s);
        chk("done", int'(done), ctrl_q[0].d);
        void'(ctrl_q.pop_front());
      end
      while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
        chk("pix_missed", pix_q[0].due, cyc);
        void'(pix_q.pop_front());
      end
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        chk("pixel", int'(pixel), pix_q[0].v);
        void'(pix_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, l, r, m;
    int x, y;
    repeat (3) @(negedge clk);
    chk("reset_select", int'(sel), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pixel", int'(pixel), 0);
    rst = 1'b0;
    idle_step(0);
    idle_step(1);
    press(1, 0, 0);
    press(0, 1, 0);
    repeat (5) press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    async_reset();
    idle_step(0);
    idle_step(1);
    repeat (3) press(0, 1, 0);
    press(1, 1, 0);
    press(0, 1, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    idle_step(0);
    step(0, 0, 0, 1, 0, 0, 7);
    repeat (3) step(1, 0, 0, 1, 0, 0, 7);
    idle_step(1);
    press(0, 0, 1);
    idle_step(0);
    idle_step(1);
    press(0, 1, 0);
    step(1, 0, 0, 0, X0 + W + G + 5, Y0 + 5, 3);
    step(1, 0, 0, 0, X0 + 5, Y0 + 5, 3);
    step(1, 0, 0, 0, X0 + W + 2, Y0 + 5, 'hA);
    step(1, 0, 0, 0, X0 + 5, Y0 + H, 'hA);
    step(1, 0, 0, 0, X0 + W - 1, Y0 + H - 1, 'hA);
    step(0, 0, 0, 0, X0 + 5, Y0 + 5, 'hA);
    step(0, 0, 0, 0, X0 + W + G + 5, Y0 + 5, 'hA);
    idle_step(1);
    repeat (13) step(1, 0, 1, 0, 0, 0, 1);
    idle_step(1);
    repeat (9) step(1, 1, 0, 0, 0, 0, 1);
    idle_step(0);
    a = 0; l = 0; r = 0; m = 0;
    for (int i = 0; i < 3000; i++) begin
      if (a) a = $urandom_range(0, 59) != 0;
      else a = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 5) == 0) l = !l;
      if ($urandom_range(0, 5) == 0) r = !r;
      if ($urandom_range(0, 15) == 0) m = !m;
      x = $urandom_range(0, 1) ? int'($urandom_range(0, 2047)) : X0 - 10 + int'($urandom_range(0, N * (W + G) + 20));
      y = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) : Y0 - 8 + int'($urandom_range(0, H + 16));
      step(a, l, r, m, x, y, int'($urandom_range(0, 15)));
    end
    idle_step(0);
    repeat (4) @(negedge clk);
    chk("ctrl_q_drained", ctrl_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
